align_add_fp: RTL

//  Multi-cycle floating-point adder/subtractor front end. Aligns two operands
//  by shifting the smaller-exponent mantissa right one bit per cycle, then adds
//  or subtracts the magnitudes. Emits an UN-normalized {sign,exp,mantissa}

---
 rtl/align_add_fp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/align_add_fp.sv
// Multi-cycle FP add/sub front end: aligns the smaller-exponent mantissa one bit
// per cycle, then adds/subtracts magnitudes and emits an un-normalized word.
module align_add_fp #(
  parameter int WIDTH  = 32,
  parameter int MAX_SH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int EW = WIDTH - 24;
  localparam int CW = $clog2(MAX_SH + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t        state;
  logic          sign_big, sign_small;
  logic [EW-1:0] exp_big, exp_small;
  logic [22:0]   mant_big, mant_small;
  logic [CW-1:0] count;

  logic [23:0]      sum;
  logic [22:0]      diff;
  logic             big_ge;
  logic [EW-1:0]    exp_inc;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_ovf;

  always_comb begin
    sum     = {1'b0, mant_big} + {1'b0, mant_small};
    big_ge  = (mant_big >= mant_small);
    diff    = big_ge ? (mant_big - mant_small) : (mant_small - mant_big);
    exp_inc = exp_big + 1'b1;
    nxt_res = '0;
    nxt_ovf = 1'b0;
    if (sign_big == sign_small) begin
      if (sum[23]) begin
        if (&exp_big) begin
          // carry out of the largest exponent saturates rather than wrapping
          nxt_res = {sign_big, {EW{1'b1}}, 23'h7FFFFF};
          nxt_ovf = 1'b1;
        end else begin
          nxt_res = {sign_big, exp_inc, sum[23:1]};
        end
      end else begin
        nxt_res = {sign_big, exp_big, sum[22:0]};
      end
    end else if (diff != 23'd0) begin
      nxt_res = {(big_ge ? sign_big : sign_small), exp_big, diff};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_big    <= '0;
      exp_small  <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // ties go to a so the operand order is deterministic
            if (b[WIDTH-2:23] > a[WIDTH-2:23]) begin
              {sign_big, exp_big, mant_big}       <= b;
              {sign_small, exp_small, mant_small} <= a;
            end else begin
              {sign_big, exp_big, mant_big}       <= a;
              {sign_small, exp_small, mant_small} <= b;
            end
            count <= '0;
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (exp_small == exp_big) begin
            state <= ADD;
          end else if (count == CW'(MAX_SH)) begin
            mant_small <= '0;
            exp_small  <= exp_big;
            state      <= ADD;
          end else begin
            mant_small <= mant_small >> 1;
            exp_small  <= exp_small + 1'b1;
            count      <= count + 1'b1;
          end
        end
        ADD: begin
          result   <= nxt_res;
          overflow <= nxt_ovf;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
